idexe_pipe_fwd: RTL and testbench
=================================

Name: idexe_pipe_fwd

Overview:
- Parametrised decode-to-execute pipeline register for the pipelined CPU.
- Adds a valid bit, downstream hold, flush-to-bubble, load-use hazard detection, and ID-side operand forwarding from the EXE and MEM stages.
- Adds a saturating bubble counter.
- Sits between the decode stage (control unit, regfile, sign extend, dest mux) and the ALU/EXE stage.

Parameters:
DATA_W, 32, operand and immediate width
RADDR_W, 5, register address width
ALUC_W, 4, ALU control width
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode slot holds a real instruction
id_wreg  in  1  decode: write register file
id_m2reg  in  1  decode: load (result from memory)
id_wmem  in  1  decode: store
id_aluc  in  ALUC_W  decode ALU control
id_aluimm  in  1  decode: ALU B operand is immediate
id_rs  in  RADDR_W  source register A
id_rt  in  RADDR_W  source register B
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_dest  in  RADDR_W  destination register (after rt/rd mux)
id_qa  in  DATA_W  regfile port A
id_qb  in  DATA_W  regfile port B
id_imm32  in  DATA_W  sign-extended immediate
exe_fwd_data  in  DATA_W  ALU result of the instruction currently in EXE
mem_wreg  in  1  MEM-stage instruction writes register
mem_dest  in  RADDR_W  MEM-stage destination
mem_fwd_data  in  DATA_W  MEM-stage writeback value
flush  in  1  kill the decode instruction (insert bubble)
hold  in  1  downstream stall: freeze the EXE registers
id_ready  out  1  decode may advance this cycle
hazard_stall  out  1  load-use hazard detected (combinational)
e_valid  out  1  EXE slot valid
ewreg  out  1  registered wreg
em2reg  out  1  registered m2reg
ewmem  out  1  registered wmem
ealuc  out  ALUC_W  registered aluc
ealuimm  out  1  registered aluimm
edest  out  RADDR_W  registered destination
eqa  out  DATA_W  registered (forwarded) operand A
eqb  out  DATA_W  registered (forwarded) operand B
eimm32  out  DATA_W  registered immediate
bubble_cnt  out  CNT_W  count of bubbles inserted

Behaviour:
- Reset (rst_n=0, asynchronous): every registered output and bubble_cnt go to 0 immediately. Reset mid-operation discards the EXE contents.
- Write qualifiers: an EXE write is live when e_valid & ewreg. A MEM write is live when mem_wreg. Destination register 0 never matches for forwarding or hazard detection.
- hazard_stall (combinational) =
  - id_valid & e_valid & ewreg & em2reg & edest!=0, and
  - ((id_use_rs & edest==id_rs) | (id_use_rt & edest==id_rt)).
- id_ready = !hold & !hazard_stall.
- Forward A, applied before latching:
  - live EXE write, non-load, edest==id_rs -> exe_fwd_data;
  - else live MEM write, mem_dest==id_rs -> mem_fwd_data;
  - else id_qa.
  - EXE has priority over MEM.
- Forward B: same rule using id_rt and id_qb.
- Rising-edge update, highest priority first:
  1. hold=1: all E registers keep their value, even if flush or hazard_stall is asserted; bubble_cnt unchanged.
  2. flush=1: insert a bubble — e_valid, ewreg, em2reg and ewmem are 0, the other fields are don't-care and are driven to 0; bubble_cnt +1.
  3. hazard_stall=1: insert a bubble (same as flush); bubble_cnt +1. The decode stage holds its instruction because id_ready=0, so the bubble is inserted exactly once per hazard cycle.
  4. Otherwise: latch the decode fields and the forwarded operands. e_valid=id_valid. ewreg and ewmem are gated by id_valid, so an invalid slot never writes.
- bubble_cnt saturates at 2^CNT_W-1 and does not wrap.
- Latency: 1 cycle from decode to E outputs.
- A load-use hazard costs exactly 1 bubble. The following cycle, the load sits in MEM and its data is forwarded through mem_fwd_data.

Test Plan:
- Reset: drive rst_n low mid-run with e_valid=1 and eqa=0x1234 -> all outputs read 0 immediately without a clock edge; bubble_cnt=0.
- Plain add: id_valid=1, aluc=0010, id_qa=5, id_qb=7, no matches -> next cycle e_valid=1, ewreg=1, eqa=5, eqb=7, ealuc=0010.
- EXE forwarding: EXE holds a non-load writing $3, exe_fwd_data=0x10; decode `sub` with rs=3, and MEM also writes $3 with 0x20 -> eqa=0x10, because EXE has priority.
- Load-use: EXE holds lw with edest=$4; decode add with rt=4 -> hazard_stall=1 and id_ready=0; next cycle e_valid=0, ewreg=0, bubble_cnt=1. Following cycle with mem_dest=4 and mem_fwd_data=0x99 -> eqb=0x99.
- Register 0: EXE writes $0 with 0xFF; decode reads rs=0 with id_qa=0 -> eqa=0, no hazard even if the EXE instruction is a load.
- Hold vs flush: hold=1 and flush=1 together -> E registers unchanged and bubble_cnt unchanged. With CNT_W=2, four flushes -> bubble_cnt saturates at 3.

Source files
------------

// File: rtl/idexe_pipe_fwd.sv
// Decode-to-execute pipeline register with valid/hold/flush,
// load-use hazard detection and ID-side EXE/MEM operand forwarding.
module idexe_pipe_fwd #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int ALUC_W  = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic               id_wreg,
  input  logic               id_m2reg,
  input  logic               id_wmem,
  input  logic [ALUC_W-1:0]  id_aluc,
  input  logic               id_aluimm,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic               id_use_rs,
  input  logic               id_use_rt,
  input  logic [RADDR_W-1:0] id_dest,
  input  logic [DATA_W-1:0]  id_qa,
  input  logic [DATA_W-1:0]  id_qb,
  input  logic [DATA_W-1:0]  id_imm32,
  input  logic [DATA_W-1:0]  exe_fwd_data,
  input  logic               mem_wreg,
  input  logic [RADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0]  mem_fwd_data,
  input  logic               flush,
  input  logic               hold,
  output logic               id_ready,
  output logic               hazard_stall,
  output logic               e_valid,
  output logic               ewreg,
  output logic               em2reg,
  output logic               ewmem,
  output logic [ALUC_W-1:0]  ealuc,
  output logic               ealuimm,
  output logic [RADDR_W-1:0] edest,
  output logic [DATA_W-1:0]  eqa,
  output logic [DATA_W-1:0]  eqb,
  output logic [DATA_W-1:0]  eimm32,
  output logic [CNT_W-1:0]   bubble_cnt
);

  typedef struct packed {
    logic               valid;
    logic               wreg;
    logic               m2reg;
    logic               wmem;
    logic [ALUC_W-1:0]  aluc;
    logic               aluimm;
    logic [RADDR_W-1:0] dest;
    logic [DATA_W-1:0]  qa;
    logic [DATA_W-1:0]  qb;
    logic [DATA_W-1:0]  imm;
  } ex_t;

  ex_t             ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic exe_live, exe_nz, mem_live, mem_nz;
  logic exe_hit_a, exe_hit_b;
  logic mem_hit_a, mem_hit_b;
  logic hz_rs, hz_rt;
  logic [DATA_W-1:0] fwd_a, fwd_b;

  assign exe_nz   = (ex_q.dest != '0);
  assign exe_live = ex_q.valid & ex_q.wreg & exe_nz;
  assign mem_nz   = (mem_dest != '0);
  assign mem_live = mem_wreg & mem_nz;

  // A load in EXE has no result yet: it stalls instead of forwarding.
  assign exe_hit_a = exe_live & ~ex_q.m2reg
                   & (ex_q.dest == id_rs);
  assign exe_hit_b = exe_live & ~ex_q.m2reg
                   & (ex_q.dest == id_rt);
  assign mem_hit_a = mem_live & (mem_dest == id_rs);
  assign mem_hit_b = mem_live & (mem_dest == id_rt);

  assign hz_rs = id_use_rs & (ex_q.dest == id_rs);
  assign hz_rt = id_use_rt & (ex_q.dest == id_rt);

  assign hazard_stall = id_valid & exe_live
                      & ex_q.m2reg & (hz_rs | hz_rt);
  assign id_ready     = ~hold & ~hazard_stall;

  always_comb begin
    fwd_a = id_qa;
    if (exe_hit_a)      fwd_a = exe_fwd_data;
    else if (mem_hit_a) fwd_a = mem_fwd_data;
  end

  always_comb begin
    fwd_b = id_qb;
    if (exe_hit_b)      fwd_b = exe_fwd_data;
    else if (mem_hit_b) fwd_b = mem_fwd_data;
  end

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (!hold) begin
      if (flush | hazard_stall) begin
        ex_d = '0;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        ex_d.valid  = id_valid;
        ex_d.wreg   = id_wreg & id_valid;
        ex_d.m2reg  = id_m2reg;
        ex_d.wmem   = id_wmem & id_valid;
        ex_d.aluc   = id_aluc;
        ex_d.aluimm = id_aluimm;
        ex_d.dest   = id_dest;
        ex_d.qa     = fwd_a;
        ex_d.qb     = fwd_b;
        ex_d.imm    = id_imm32;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign e_valid    = ex_q.valid;
  assign ewreg      = ex_q.wreg;
  assign em2reg     = ex_q.m2reg;
  assign ewmem      = ex_q.wmem;
  assign ealuc      = ex_q.aluc;
  assign ealuimm    = ex_q.aluimm;
  assign edest      = ex_q.dest;
  assign eqa        = ex_q.qa;
  assign eqb        = ex_q.qb;
  assign eimm32     = ex_q.imm;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_idexe_pipe_fwd.sv
// Randomized + directed bench for idexe_pipe_fwd against
// a behavioural model of the ID/EXE register.
module tb_idexe_pipe_fwd;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        id_valid, id_wreg, id_m2reg, id_wmem;
  logic [3:0]  id_aluc;
  logic        id_aluimm;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_use_rs, id_use_rt;
  logic [31:0] id_qa, id_qb, id_imm32;
  logic [31:0] exe_fwd_data, mem_fwd_data;
  logic        mem_wreg;
  logic [4:0]  mem_dest;
  logic        flush, hold;

  logic        id_ready, hazard_stall;
  logic        e_valid, ewreg, em2reg, ewmem;
  logic [3:0]  ealuc;
  logic        ealuimm;
  logic [4:0]  edest;
  logic [31:0] eqa, eqb, eimm32;
  logic [15:0] bubble_cnt;

  logic        s_ready, s_hz, s_valid, s_wreg, s_m2reg, s_wmem;
  logic [3:0]  s_aluc;
  logic        s_aluimm;
  logic [4:0]  s_dest;
  logic [31:0] s_qa, s_qb, s_imm;
  logic [1:0]  s_cnt;

  idexe_pipe_fwd dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .id_wmem(id_wmem),
    .id_aluc(id_aluc), .id_aluimm(id_aluimm),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_dest(id_dest), .id_qa(id_qa), .id_qb(id_qb),
    .id_imm32(id_imm32), .exe_fwd_data(exe_fwd_data),
    .mem_wreg(mem_wreg), .mem_dest(mem_dest),
    .mem_fwd_data(mem_fwd_data),
    .flush(flush), .hold(hold),
    .id_ready(id_ready), .hazard_stall(hazard_stall),
    .e_valid(e_valid), .ewreg(ewreg), .em2reg(em2reg),
    .ewmem(ewmem), .ealuc(ealuc), .ealuimm(ealuimm),
    .edest(edest), .eqa(eqa), .eqb(eqb),
    .eimm32(eimm32), .bubble_cnt(bubble_cnt)
  );

  idexe_pipe_fwd #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .id_wmem(id_wmem),
    .id_aluc(id_aluc), .id_aluimm(id_aluimm),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_dest(id_dest), .id_qa(id_qa), .id_qb(id_qb),
    .id_imm32(id_imm32), .exe_fwd_data(exe_fwd_data),
    .mem_wreg(mem_wreg), .mem_dest(mem_dest),
    .mem_fwd_data(mem_fwd_data),
    .flush(flush), .hold(hold),
    .id_ready(s_ready), .hazard_stall(s_hz),
    .e_valid(s_valid), .ewreg(s_wreg), .em2reg(s_m2reg),
    .ewmem(s_wmem), .ealuc(s_aluc), .ealuimm(s_aluimm),
    .edest(s_dest), .eqa(s_qa), .eqb(s_qb),
    .eimm32(s_imm), .bubble_cnt(s_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // reference model state
  logic        m_valid, m_wreg, m_m2reg, m_wmem, m_aluimm;
  logic [3:0]  m_aluc;
  logic [4:0]  m_dest;
  logic [31:0] m_qa, m_qb, m_imm;
  int          m_cnt;

  task automatic m_clear();
    m_valid = 0; m_wreg = 0; m_m2reg = 0; m_wmem = 0;
    m_aluimm = 0; m_aluc = 0; m_dest = 0;
    m_qa = 0; m_qb = 0; m_imm = 0;
  endtask

  function automatic bit m_hazard();
    bit ld;
    ld = m_valid && m_wreg && m_m2reg && m_dest != 0;
    return id_valid && ld &&
      ((id_use_rs && m_dest == id_rs) ||
       (id_use_rt && m_dest == id_rt));
  endfunction

  function automatic logic [31:0] m_fwd(
      input logic [4:0] r, input logic [31:0] rf);
    if (m_valid && m_wreg && !m_m2reg &&
        m_dest != 0 && m_dest == r)
      return exe_fwd_data;
    if (mem_wreg && mem_dest != 0 && mem_dest == r)
      return mem_fwd_data;
    return rf;
  endfunction

  task automatic check_outs();
    chk("e_valid", e_valid, m_valid);
    chk("ewreg", ewreg, m_wreg);
    chk("em2reg", em2reg, m_m2reg);
    chk("ewmem", ewmem, m_wmem);
    chk("ealuc", ealuc, m_aluc);
    chk("ealuimm", ealuimm, m_aluimm);
    chk("edest", edest, m_dest);
    chk("eqa", eqa, m_qa);
    chk("eqb", eqb, m_qb);
    chk("eimm32", eimm32, m_imm);
    chk("bubble_cnt", bubble_cnt,
        (m_cnt > 65535) ? 65535 : m_cnt);
    chk("sat_cnt", s_cnt, (m_cnt > 3) ? 3 : m_cnt);
  endtask

  // inputs set just after negedge; evaluate, clock, re-check
  task automatic step();
    bit hz;
    logic [31:0] na, nb;
    #1;
    hz = m_hazard();
    chk("hazard_stall", hazard_stall, hz);
    chk("id_ready", id_ready, !hold && !hz);
    na = m_fwd(id_rs, id_qa);
    nb = m_fwd(id_rt, id_qb);
    if (!hold) begin
      if (flush || hz) begin
        m_clear();
        m_cnt++;
      end else begin
        m_valid = id_valid;
        m_wreg = id_wreg && id_valid;
        m_wmem = id_wmem && id_valid;
        m_m2reg = id_m2reg;
        m_aluc = id_aluc;
        m_aluimm = id_aluimm;
        m_dest = id_dest;
        m_qa = na;
        m_qb = nb;
        m_imm = id_imm32;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outs();
  endtask

  task automatic idle();
    id_valid = 0; id_wreg = 0; id_m2reg = 0; id_wmem = 0;
    id_aluc = 0; id_aluimm = 0; id_rs = 0; id_rt = 0;
    id_use_rs = 0; id_use_rt = 0; id_dest = 0;
    id_qa = 0; id_qb = 0; id_imm32 = 0;
    exe_fwd_data = 0; mem_fwd_data = 0;
    mem_wreg = 0; mem_dest = 0; flush = 0; hold = 0;
  endtask

  task automatic instr(input logic [3:0] aluc,
                       input logic [4:0] rs,
                       input logic [4:0] rt,
                       input logic [4:0] dst,
                       input logic ld);
    idle();
    id_valid = 1; id_wreg = 1; id_m2reg = ld;
    id_aluc = aluc; id_rs = rs; id_rt = rt;
    id_use_rs = 1; id_use_rt = 1; id_dest = dst;
  endtask

  task automatic rand_in();
    id_valid = 1'($urandom);
    id_wreg = 1'($urandom);
    id_m2reg = ($urandom_range(0, 2) == 0);
    id_wmem = ($urandom_range(0, 3) == 0);
    id_aluc = 4'($urandom);
    id_aluimm = 1'($urandom);
    id_rs = 5'($urandom_range(0, 3));
    id_rt = 5'($urandom_range(0, 3));
    id_dest = 5'($urandom_range(0, 3));
    id_use_rs = 1'($urandom);
    id_use_rt = 1'($urandom);
    id_qa = $urandom;
    id_qb = $urandom;
    id_imm32 = $urandom;
    exe_fwd_data = $urandom;
    mem_fwd_data = $urandom;
    mem_wreg = 1'($urandom);
    mem_dest = 5'($urandom_range(0, 3));
    flush = ($urandom_range(0, 7) == 0);
    hold = ($urandom_range(0, 7) == 0);
  endtask

  logic [31:0] sv_qa;
  int          sv_cnt;

  initial begin
    idle();
    m_clear();
    m_cnt = 0;
    rst_n = 0;
    #3;
    check_outs();
    @(negedge clk);
    rst_n = 1;

    // plain add
    instr(4'b0010, 5'd1, 5'd2, 5'd5, 0);
    id_qa = 5; id_qb = 7;
    step();
    chk("add_eqa", eqa, 32'd5);
    chk("add_eqb", eqb, 32'd7);
    chk("add_aluc", ealuc, 4'b0010);

    // EXE beats MEM
    instr(4'b0010, 5'd1, 5'd2, 5'd3, 0);
    step();
    instr(4'b0110, 5'd3, 5'd2, 5'd6, 0);
    id_qa = 32'hdead;
    exe_fwd_data = 32'h10;
    mem_wreg = 1; mem_dest = 3; mem_fwd_data = 32'h20;
    step();
    chk("fwd_exe_prio", eqa, 32'h10);

    // load-use
    instr(4'b0010, 5'd1, 5'd0, 5'd4, 1);
    step();
    instr(4'b0010, 5'd1, 5'd4, 5'd7, 0);
    id_qb = 32'h1;
    #1;
    chk("lu_hazard", hazard_stall, 1'b1);
    chk("lu_ready", id_ready, 1'b0);
    step();
    chk("lu_bubble", e_valid, 1'b0);
    chk("lu_cnt", bubble_cnt, 16'd1);
    mem_wreg = 1; mem_dest = 4; mem_fwd_data = 32'h99;
    step();
    chk("lu_memfwd", eqb, 32'h99);

    // register 0 never matches
    instr(4'b0010, 5'd1, 5'd1, 5'd0, 1);
    step();
    instr(4'b0010, 5'd0, 5'd1, 5'd8, 0);
    exe_fwd_data = 32'hff;
    #1;
    chk("r0_hazard", hazard_stall, 1'b0);
    step();
    chk("r0_eqa", eqa, 32'h0);

    // hold outranks flush
    sv_qa = m_qa;
    sv_cnt = m_cnt;
    instr(4'b1111, 5'd2, 5'd2, 5'd9, 0);
    id_qa = 32'h5555;
    hold = 1; flush = 1;
    step();
    chk("hold_eqa", eqa, sv_qa);
    chk("hold_cnt", bubble_cnt, sv_cnt);

    // saturation of the narrow counter
    idle();
    for (int i = 0; i < 4; i++) begin
      flush = 1;
      step();
    end
    chk("sat_at_3", s_cnt, 2'd3);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      rand_in();
      step();
    end

    // async reset mid-run
    instr(4'b0001, 5'd0, 5'd0, 5'd2, 0);
    id_qa = 32'h1234;
    step();
    chk("pre_rst_eqa", eqa, 32'h1234);
    chk("pre_rst_val", e_valid, 1'b1);
    #2;
    rst_n = 0;
    #1;
    m_clear();
    m_cnt = 0;
    check_outs();
    @(negedge clk);
    rst_n = 1;
    idle();
    step();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout obs=running exp=done");
    $fatal(1, "timeout");
  end

endmodule
